// File: rtl/intra_pkg.sv
// Shared intra-prediction definitions: TU size encodings, block counts and 4x4 row layout.
package intra_pkg;

    localparam logic [2:0] TU4  = 3'd2;
    localparam logic [2:0] TU8  = 3'd3;
    localparam logic [2:0] TU16 = 3'd4;
    localparam logic [2:0] TU32 = 3'd5;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_EMIT = 1'b1
    } ser_state_t;

    // Number of 4x4 blocks in a TU; unknown encodings count as a single block.
    function automatic logic [6:0] tu_nblk(input logic [2:0] tu_size);
        case (tu_size)
            TU4:     tu_nblk = 7'd1;
            TU8:     tu_nblk = 7'd4;
            TU16:    tu_nblk = 7'd16;
            TU32:    tu_nblk = 7'd64;
            default: tu_nblk = 7'd1;
        endcase
    endfunction

    // MSB index of row `row` in a 16-pixel block, row 0 at the top of the vector.
    function automatic int unsigned row_msb(input int unsigned bit_depth, input logic [1:0] row);
        row_msb = bit_depth * 16 - 1 - bit_depth * 4 * 32'(row);
    endfunction

endpackage

// File: rtl/intra_blk_fifo.sv
// Generic DEPTH-entry synchronous FIFO with registered full/empty flags and occupancy count.
// Latency: written entry visible at pop_dat the cycle after push.
// Backpressure: push ignored while full, pop ignored while empty.
module intra_blk_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign cnt_nxt = count + CW'(do_push) - CW'(do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= cnt_nxt;
            full  <= (cnt_nxt == CW'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/intra_pred_blk_sink.sv
// Sinks 4x4 predSamples blocks, buffers them and emits four row beats per block with pixel coordinates.
// Latency: row 0 is presented the cycle after the block transfer; one block per 4 cycles sustained.
// Backpressure: bStop is the registered FIFO-full flag; out_ready=0 holds the current beat stable.
module intra_pred_blk_sink
    import intra_pkg::*;
#(
    parameter int bitDepth = 8,
    parameter int DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [bitDepth*16-1:0]  predSamples,
    input  logic [2:0]              X,
    input  logic [2:0]              Y,
    input  logic [2:0]              tuSize,
    output logic                    bStop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [bitDepth*4-1:0]   out_row,
    output logic [4:0]              out_x,
    output logic [4:0]              out_y,
    output logic                    out_last_row,
    output logic                    tu_done,
    output logic                    err_tusize
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [bitDepth*16-1:0] pix;
        logic [2:0]             x;
        logic [2:0]             y;
        logic                   last;
    } entry_t;

    entry_t     wr_ent;
    entry_t     head;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [CW-1:0] count;

    logic [5:0] in_cnt;
    logic [5:0] cnt_base;
    logic [2:0] tu_prev;
    logic       tu_legal;
    logic       tu_changed;
    logic       blk_last;

    ser_state_t state, state_nxt;
    logic [1:0] r, r_nxt;

    assign bStop = full;
    assign push  = in_valid && !full;
    assign pop   = out_valid && out_ready && (r == 2'd3);

    // A new TU starts on an illegal size or a size change mid-TU.
    assign tu_legal   = (tuSize >= TU4) && (tuSize <= TU32);
    assign tu_changed = (in_cnt != 6'd0) && (tuSize != tu_prev);
    assign cnt_base   = (!tu_legal || tu_changed) ? 6'd0 : in_cnt;
    assign blk_last   = ({1'b0, cnt_base} == tu_nblk(tuSize) - 7'd1);

    assign wr_ent = '{pix: predSamples, x: X, y: Y, last: blk_last};

    intra_blk_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (wr_ent),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt     <= '0;
            tu_prev    <= '0;
            err_tusize <= 1'b0;
        end else if (push) begin
            in_cnt  <= blk_last ? 6'd0 : cnt_base + 6'd1;
            tu_prev <= tuSize;
            if (!tu_legal || tu_changed) err_tusize <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SER_IDLE;
            r       <= '0;
            tu_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            r       <= r_nxt;
            tu_done <= pop && head.last;
        end
    end

    // EMIT mirrors a non-empty FIFO; it is left only when the last entry pops with no refill.
    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        case (state)
            SER_IDLE: begin
                if (push) state_nxt = SER_EMIT;
            end
            SER_EMIT: begin
                if (out_ready) begin
                    r_nxt = r + 2'd1;
                    if (r == 2'd3 && count == CW'(1) && !push) state_nxt = SER_IDLE;
                end
            end
            default: state_nxt = SER_IDLE;
        endcase
    end

    assign out_valid    = (state == SER_EMIT);
    assign out_row      = out_valid ? head.pix[row_msb(bitDepth, r) -: bitDepth*4] : '0;
    assign out_x        = out_valid ? {head.x, 2'b00} : 5'd0;
    assign out_y        = out_valid ? ({head.y, 2'b00} + {3'b000, r}) : 5'd0;
    assign out_last_row = out_valid && (r == 2'd3);

    logic unused_empty;
    assign unused_empty = empty;

endmodule
